// File: rtl/serial_pattern_matcher_pkg.sv
// Shared types and default sizes for the serial pattern matcher.
package serial_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HUNT = 2'd2
    } state_t;

    localparam int DEF_PAT_W = 8;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/serial_pattern_matcher_if.sv
// Control/data bundle for serial_pattern_matcher; mask_in exists only with PATTERN_MASK_EN.
interface serial_pattern_matcher_if #(
    parameter int PAT_W = serial_pattern_pkg::DEF_PAT_W,
    parameter int CNT_W = serial_pattern_pkg::DEF_CNT_W
);
    // No backpressure: enable qualifies serial_in for exactly one bit per cycle,
    // load is a one-cycle command, match is a one-cycle registered pulse.
    logic             load;
    logic [PAT_W-1:0] pattern_in;
`ifdef PATTERN_MASK_EN
    logic [PAT_W-1:0] mask_in;
`endif
    logic             enable;
    logic             serial_in;
    logic             overlap;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             armed;

    modport master (
        output load, pattern_in,
`ifdef PATTERN_MASK_EN
        output mask_in,
`endif
        output enable, serial_in, overlap,
        input  match, match_count, armed
    );

    modport slave (
        input  load, pattern_in,
`ifdef PATTERN_MASK_EN
        input  mask_in,
`endif
        input  enable, serial_in, overlap,
        output match, match_count, armed
    );
endinterface

// File: rtl/serial_pattern_matcher_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] MAX_VAL = '1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX_VAL)) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/serial_pattern_matcher.sv
// Serial bit-pattern detector with fill qualification, overlap mode and saturating match count.
// Optional don't-care mask enabled by defining PATTERN_MASK_EN.
module serial_pattern_matcher
    import serial_pattern_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    serial_pattern_matcher_if.slave   bus,
    output state_t                    dbg_state
);
    localparam int FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(PAT_W - 1);

    state_t            state_q;
    logic [PAT_W-1:0]  shift_q;
    logic [PAT_W-1:0]  pattern_q;
    logic [PAT_W-1:0]  cmp_mask;
    logic [PAT_W-1:0]  next_shift;
    logic [FILL_W-1:0] fill_q;
    logic              match_q;
    logic              armed_q;
    logic              shift_en;
    logic              complete;
    logic              hit;
    logic              lsb_unused;
    logic [CNT_W-1:0]  count_w;

`ifdef PATTERN_MASK_EN
    logic [PAT_W-1:0]  mask_q;
    assign cmp_mask = mask_q;
`else
    assign cmp_mask = '1;
`endif

    // The oldest bit falls off the LSB; it is never compared again.
    assign lsb_unused = shift_q[0];
    assign next_shift = {bus.serial_in, shift_q[PAT_W-1:1]};
    assign shift_en   = bus.enable && !bus.load && (state_q != IDLE);
    assign complete   = (state_q == HUNT) || ((state_q == FILL) && (fill_q == LAST_FILL));
    assign hit        = shift_en && complete && (((next_shift ^ pattern_q) & cmp_mask) == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            pattern_q <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            armed_q   <= 1'b0;
`ifdef PATTERN_MASK_EN
            mask_q    <= '0;
`endif
        end else begin
            match_q <= 1'b0;
            if (bus.load) begin
                pattern_q <= bus.pattern_in;
`ifdef PATTERN_MASK_EN
                mask_q    <= bus.mask_in;
`endif
                shift_q   <= '0;
                fill_q    <= '0;
                state_q   <= FILL;
                armed_q   <= 1'b0;
            end else if (shift_en) begin
                shift_q <= next_shift;
                match_q <= hit;
                // Non-overlapping mode demands PAT_W fresh bits after every match.
                if (hit && !bus.overlap) begin
                    fill_q  <= '0;
                    state_q <= FILL;
                    armed_q <= 1'b0;
                end else if (complete) begin
                    state_q <= HUNT;
                    armed_q <= 1'b1;
                end else begin
                    fill_q <= fill_q + 1'b1;
                end
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_match_count (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (hit),
        .clr     (bus.load),
        .count   (count_w)
    );

    assign bus.match       = match_q;
    assign bus.armed       = armed_q;
    assign bus.match_count = count_w;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_serial_pattern_matcher.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_serial_pattern_matcher;
    import serial_pattern_pkg::*;

    localparam int PW   = 5;
    localparam int CW   = 2;
    localparam int MAXC = 3;

    logic   clk = 1'b0;
    logic   reset_n;
    state_t dbg_state;

    serial_pattern_matcher_if #(.PAT_W(PW), .CNT_W(CW)) bus();

    serial_pattern_matcher #(.PAT_W(PW), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: bit history since load, count of fresh bits since last restart.
    bit         hist[$];
    bit         loaded_m;
    int         fresh_m;
    int         cnt_m;
    logic [PW-1:0] pat_m;
    logic [PW-1:0] mask_m;
    logic       exp_match;
    logic       exp_armed;
    bit         m_hit;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist.delete();
            loaded_m  = 1'b0;
            fresh_m   = 0;
            cnt_m     = 0;
            pat_m     = '0;
            mask_m    = '1;
            exp_match = 1'b0;
            exp_armed = 1'b0;
        end else begin
            exp_match = 1'b0;
            if (bus.load) begin
                hist.delete();
                loaded_m = 1'b1;
                fresh_m  = 0;
                cnt_m    = 0;
                pat_m    = bus.pattern_in;
`ifdef PATTERN_MASK_EN
                mask_m   = bus.mask_in;
`else
                mask_m   = '1;
`endif
            end else if (bus.enable && loaded_m) begin
                hist.push_back(bus.serial_in);
                if (hist.size() > PW) void'(hist.pop_front());
                fresh_m = (fresh_m < PW) ? fresh_m + 1 : PW;
                if (fresh_m == PW) begin
                    m_hit = 1'b1;
                    for (int i = 0; i < PW; i++)
                        if (mask_m[i] && (hist[i] != pat_m[i])) m_hit = 1'b0;
                    if (m_hit) begin
                        exp_match = 1'b1;
                        if (cnt_m < MAXC) cnt_m++;
                        if (!bus.overlap) fresh_m = 0;
                    end
                end
            end
            exp_armed = loaded_m && (fresh_m == PW);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("match", bus.match, exp_match);
            check("match_count", bus.match_count, cnt_m);
            check("armed", bus.armed, exp_armed);
            if (bus.match === 1'b1) pulses++;
        end
    end

    task automatic do_load(input logic [PW-1:0] p, input logic [PW-1:0] m);
        @(negedge clk);
        bus.load       = 1'b1;
        bus.enable     = 1'b0;
        bus.pattern_in = p;
`ifdef PATTERN_MASK_EN
        bus.mask_in    = m;
`else
        if (m == '0) bus.pattern_in = p;
`endif
        @(negedge clk);
        bus.load = 1'b0;
        pulses   = 0;
    endtask

    task automatic send_bits(input int n, input logic [15:0] bits);
        logic [15:0] b;
        b = bits;
        for (int i = 0; i < n; i++) begin
            bus.enable    = 1'b1;
            bus.serial_in = b[i];
            @(negedge clk);
        end
        bus.enable = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int r;
        reset_n        = 1'b0;
        bus.load       = 1'b0;
        bus.pattern_in = '0;
`ifdef PATTERN_MASK_EN
        bus.mask_in    = '1;
`endif
        bus.enable     = 1'b0;
        bus.serial_in  = 1'b0;
        bus.overlap    = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_match", bus.match, 0);
        check("reset_count", bus.match_count, 0);
        check("reset_armed", bus.armed, 0);
        check("reset_state", dbg_state, IDLE);
        reset_n = 1'b1;
        chk_on  = 1'b1;

        // enable while IDLE must not shift or arm
        send_bits(6, 16'h003F);
        check("idle_armed", bus.armed, 0);
        check("idle_pulses", pulses, 0);

        // basic match, stream 0,1,1,0,1
        bus.overlap = 1'b1;
        do_load(5'b10110, 5'b11111);
        send_bits(5, 16'h0016);
        check("t1_pulses", pulses, 1);
        check("t1_count", bus.match_count, 1);
        check("t1_armed", bus.armed, 1);

        // overlap vs non-overlap, stream 1,0,1,0,1,0,1
        do_load(5'b10101, 5'b11111);
        send_bits(7, 16'h0055);
        check("t2_ovl_pulses", pulses, 2);
        check("t2_ovl_count", bus.match_count, 2);
        bus.overlap = 1'b0;
        do_load(5'b10101, 5'b11111);
        send_bits(7, 16'h0055);
        check("t2_novl_pulses", pulses, 1);
        check("t2_novl_count", bus.match_count, 1);

        // zero pattern, nothing shifted
        do_load(5'b00000, 5'b11111);
        repeat (10) @(negedge clk);
        check("t3_pulses", pulses, 0);
        check("t3_armed", bus.armed, 0);

        // saturation, nine ones
        bus.overlap = 1'b1;
        do_load(5'b11111, 5'b11111);
        send_bits(9, 16'h01FF);
        check("t4_pulses", pulses, 5);
        check("t4_count", bus.match_count, 3);

        // load beats enable mid-HUNT, then asynchronous reset mid-stream
        do_load(5'b10110, 5'b11111);
        send_bits(5, 16'h0016);
        check("t5_pre_state", dbg_state, HUNT);
        bus.load      = 1'b1;
        bus.enable    = 1'b1;
        bus.serial_in = 1'b1;
        @(negedge clk);
        bus.load   = 1'b0;
        bus.enable = 1'b0;
        check("t5_count", bus.match_count, 0);
        check("t5_armed", bus.armed, 0);
        check("t5_state", dbg_state, FILL);
        send_bits(5, 16'h0016);
        check("t5_rearm_count", bus.match_count, 1);
        #2 reset_n = 1'b0;
        #1;
        check("t5_rst_match", bus.match, 0);
        check("t5_rst_count", bus.match_count, 0);
        check("t5_rst_armed", bus.armed, 0);
        check("t5_rst_state", dbg_state, IDLE);
        @(negedge clk);
        reset_n = 1'b1;

        // masked compare, stream 1,0,1,0,1
        do_load(5'b10110, 5'b11100);
        send_bits(5, 16'h0015);
`ifdef PATTERN_MASK_EN
        check("t6_mask_pulses", pulses, 1);
`else
        check("t6_nomask_pulses", pulses, 0);
`endif

        // random traffic
        do_load(5'($urandom), 5'($urandom));
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            r = $urandom_range(0, 199);
            if (r == 199) begin
                bus.load   = 1'b0;
                bus.enable = 1'b0;
                #2 reset_n = 1'b0;
                #2 reset_n = 1'b1;
            end else begin
                bus.load       = (r < 6);
                bus.pattern_in = 5'($urandom);
`ifdef PATTERN_MASK_EN
                bus.mask_in    = 5'($urandom);
`endif
                bus.enable     = ($urandom_range(0, 9) < 8);
                bus.serial_in  = 1'($urandom);
                bus.overlap    = 1'($urandom);
            end
        end
        @(negedge clk);
        bus.load   = 1'b0;
        bus.enable = 1'b0;
        repeat (2) @(negedge clk);
        chk_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
